core4_mem_fill_copy: RTL and testbench
======================================

CORE4_MEM_FILL_COPY -- requirements
Module: core4_mem_fill_copy

Interface
REQ-001 Parameter ADDR_W, default 13, word-address width of the attached on-chip memory.
REQ-002 Parameter DATA_W, default 32, memory data width; byte-enable width is DATA_W/8.
REQ-003 clk  in  1  single clock; all logic in this domain.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready are both high on a rising edge.
REQ-007 cmd_op  in  1  0 = FILL, 1 = COPY.
REQ-008 cmd_src  in  ADDR_W  COPY source word address; ignored for FILL.
REQ-009 cmd_dst  in  ADDR_W  destination word address.
REQ-010 cmd_len  in  ADDR_W+1  word count; legal range 1..2^ADDR_W.
REQ-011 cmd_pattern  in  DATA_W  FILL data word.
REQ-012 abort  in  1  level; requests early termination.
REQ-013 busy  out  1  high from the cycle after accept until the done pulse.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 status  out  2  valid with done: 0 = OK, 1 = ERR_LEN, 2 = ABORTED.
REQ-016 mem_address  out  ADDR_W  memory word address.
REQ-017 mem_chipselect, mem_write  out  1 each  memory access strobes.
REQ-018 mem_byteenable  out  DATA_W/8  always all-ones.
REQ-019 mem_writedata  out  DATA_W  write data.
REQ-020 mem_readdata  in  DATA_W  read data, valid exactly 1 cycle after the read-issue cycle.
REQ-021 mem_clken  out  1  constant 1.

Function
REQ-022 State machine states: IDLE, FILL, RD, WR, FIN; cmd_ready is high only in IDLE.
REQ-023 On accept with cmd_len == 0 or cmd_len > 2^ADDR_W: go to FIN, status ERR_LEN, with no memory access.
REQ-024 The block latches the command on accept; input changes during busy have no effect.
REQ-025 FILL: one write per cycle (chipselect=1, write=1, data=cmd_pattern), dst ascending; exits to FIN after cmd_len writes.
REQ-026 COPY: RD drives chipselect=1, write=0, address=src; the next cycle WR writes the captured mem_readdata to dst; 2 cycles per word.
REQ-027 Addresses increment modulo 2^ADDR_W, so 8191 wraps to 0.
REQ-028 COPY is strictly ascending word order; overlapping regions with dst > src propagate source data forward, and this is the defined behaviour.
REQ-029 mem_chipselect and mem_write are 0 in IDLE and FIN; no other access occurs.
REQ-030 abort sampled high in FILL or WR: the current write completes, then FIN with status ABORTED.
REQ-031 abort sampled high in RD: WR for that word still occurs, then FIN with status ABORTED.
REQ-032 abort in IDLE is ignored.
REQ-033 FIN lasts one cycle: done=1, busy=0, then IDLE. A command can be accepted in the cycle after done.
REQ-034 If abort and the final word coincide, status is OK.
REQ-035 Latency: the first memory access occurs in the cycle after accept. FILL done follows the last write by 1 cycle; COPY by 1 cycle after the last WR.

Reset
REQ-036 While reset is high: state = IDLE, cmd_ready=1, busy=0, done=0, status=0, mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0.
REQ-037 Reset asserted mid-operation terminates immediately with no done pulse; memory contents already written stay written.

Structure
REQ-038 Shared package core4_dma_pkg holds the op encoding, status encoding and state enum.
REQ-039 Implementation is a single module with no sub-modules; the word counter and two address counters are local registers.

Verification
REQ-040 FILL dst=0x0100, len=4, pattern=0xDEADBEEF -> writes on 4 consecutive cycles to 0x0100..0x0103; done 1 cycle later; status 0.
REQ-041 COPY src=0x0000, dst=0x1000, len=3, memory preloaded 0x11/0x22/0x33 -> read/write alternate over 6 cycles; 0x1000..0x1002 = 0x11/0x22/0x33.
REQ-042 FILL dst=0x1FFE, len=4 -> writes to 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-043 cmd_len=0 and cmd_len=0x2001 -> no memory strobes; done with status 1.
REQ-044 COPY len=8 with abort asserted during the 3rd RD -> exactly 3 writes; done with status 2.
REQ-045 reset asserted during the 2nd FILL write of len=10 -> strobes drop immediately; no done; the next command is accepted normally.

Source files
------------

// File: rtl/core4_dma_pkg.sv
// Shared encodings for the core4 memory fill/copy engine:
// command op, completion status and controller state.
package core4_dma_pkg;

  typedef enum logic {
    OP_FILL = 1'b0,
    OP_COPY = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ERR_LEN = 2'd1,
    ST_ABORTED = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_e;

endpackage

// File: rtl/core4_mem_fill_copy.sv
// Memory fill / copy engine: one write per cycle for FILL,
// read-then-write pairs for COPY, ascending word order.
module core4_mem_fill_copy
  import core4_dma_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic [DATA_W-1:0]   cmd_pattern,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [1:0]          status,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                mem_clken
);

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   C_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   C_MAX =
    {1'b1, {ADDR_W{1'b0}}};

  state_e              r_state;
  state_e              w_next;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [ADDR_W:0]     r_cnt;
  logic [DATA_W-1:0]   r_pattern;
  logic                r_abort;
  logic [1:0]          r_status;
  logic                w_len_bad;
  logic                w_last;

  assign w_len_bad = (cmd_len == '0) || (cmd_len > C_MAX);
  assign w_last    = (r_cnt == C_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (cmd_valid) begin
          if (w_len_bad)              w_next = S_FIN;
          else if (cmd_op == OP_COPY) w_next = S_RD;
          else                        w_next = S_FILL;
        end
      S_FILL:
        if (w_last || abort) w_next = S_FIN;
      S_RD:
        w_next = S_WR;
      S_WR:
        if (w_last || abort || r_abort) w_next = S_FIN;
        else                            w_next = S_RD;
      S_FIN:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Abort seen in RD is remembered so the paired WR still happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_cnt     <= '0;
      r_pattern <= '0;
      r_abort   <= 1'b0;
      r_status  <= ST_OK;
    end else begin
      case (r_state)
        S_IDLE:
          if (cmd_valid) begin
            r_src     <= cmd_src;
            r_dst     <= cmd_dst;
            r_cnt     <= cmd_len;
            r_pattern <= cmd_pattern;
            r_abort   <= 1'b0;
            r_status  <= w_len_bad ? ST_ERR_LEN : ST_OK;
          end
        S_FILL: begin
          r_dst <= r_dst + A_ONE;
          r_cnt <= r_cnt - C_ONE;
          if (!w_last && abort) r_status <= ST_ABORTED;
        end
        S_RD: begin
          r_src <= r_src + A_ONE;
          if (abort) r_abort <= 1'b1;
        end
        S_WR: begin
          r_dst <= r_dst + A_ONE;
          r_cnt <= r_cnt - C_ONE;
          if (!w_last && (abort || r_abort))
            r_status <= ST_ABORTED;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    case (r_state)
      S_FILL: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = r_dst;
        mem_writedata  = r_pattern;
      end
      S_RD: begin
        mem_chipselect = 1'b1;
        mem_address    = r_src;
      end
      S_WR: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = r_dst;
        mem_writedata  = mem_readdata;
      end
      default: ;
    endcase
  end

  assign cmd_ready      = (r_state == S_IDLE);
  assign busy           = (r_state == S_FILL) ||
                          (r_state == S_RD) ||
                          (r_state == S_WR);
  assign done           = (r_state == S_FIN);
  assign status         = r_status;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_core4_mem_fill_copy.sv
// Scoreboard bench for core4_mem_fill_copy: directed commands
// push expected writes/completions, a monitor pops and compares.
module tb_core4_mem_fill_copy;

  logic        clk = 0;
  logic        reset = 0;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic        cmd_op = 0;
  logic [12:0] cmd_src = 0;
  logic [12:0] cmd_dst = 0;
  logic [13:0] cmd_len = 0;
  logic [31:0] cmd_pattern = 0;
  logic        abort = 0;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [12:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 0;
  logic        mem_clken;

  core4_mem_fill_copy dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_len(cmd_len), .cmd_pattern(cmd_pattern),
    .abort(abort), .busy(busy), .done(done), .status(status),
    .mem_address(mem_address),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_clken(mem_clken)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:8191];
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_chipselect) begin
      if (mem_write) mem[mem_address] <= mem_writedata;
      else           mem_readdata <= mem[mem_address];
    end
  end

  typedef struct {
    logic [12:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;
  typedef struct {
    logic [1:0] s;
    int         c;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_chipselect && mem_write) begin
        if (wq.size() == 0) begin
          checks++;
          $display("FAIL unexpected write: addr %0h data %0h",
                   mem_address, mem_writedata);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr addr", 64'(mem_address), 64'(e.a));
          chk("wr data", 64'(mem_writedata), 64'(e.d));
          chk("wr cycle", 64'(cyc), 64'(e.c));
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++;
          $display("FAIL unexpected done: status %0d", status);
        end else begin
          dn_t e;
          e = dq.pop_front();
          chk("done status", 64'(status), 64'(e.s));
          chk("done cycle", 64'(cyc), 64'(e.c));
          chk("busy at done", 64'(busy), 64'd0);
        end
      end
    end
  end

  task automatic push_wr(logic [12:0] a, logic [31:0] d, int c);
    wr_t e;
    e.a = a; e.d = d; e.c = c;
    wq.push_back(e);
  endtask

  task automatic push_dn(logic [1:0] s, int c);
    dn_t e;
    e.s = s; e.c = c;
    dq.push_back(e);
  endtask

  // Call at a negedge; returns #1 after the accepting edge.
  task automatic issue(logic op, logic [12:0] src,
                       logic [12:0] dst, logic [13:0] len,
                       logic [31:0] pat, logic exp_busy,
                       output int a);
    chk("cmd_ready idle", 64'(cmd_ready), 64'd1);
    cmd_op = op; cmd_src = src; cmd_dst = dst;
    cmd_len = len; cmd_pattern = pat; cmd_valid = 1;
    @(posedge clk); #1;
    a = cyc;
    cmd_valid = 0;
    cmd_op = ~op; cmd_src = ~src; cmd_dst = ~dst;
    cmd_len = 14'd5; cmd_pattern = ~pat;
    chk("busy after accept", 64'(busy), 64'(exp_busy));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (wq.size() == 0 && dq.size() == 0 && cmd_ready)
        return;
    end
    checks++;
    $display("FAIL timeout: wq %0d dq %0d pending",
             wq.size(), dq.size());
    wq.delete();
    dq.delete();
  endtask

  initial begin
    int a;
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    #2 reset = 1;
    @(negedge clk); @(negedge clk);
    chk("rst cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst status", 64'(status), 64'd0);
    chk("rst cs", 64'(mem_chipselect), 64'd0);
    chk("rst write", 64'(mem_write), 64'd0);
    chk("rst addr", 64'(mem_address), 64'd0);
    chk("rst wdata", 64'(mem_writedata), 64'd0);
    chk("rst clken", 64'(mem_clken), 64'd1);
    chk("rst be", 64'(mem_byteenable), 64'hF);
    reset = 0;
    @(negedge clk);

    issue(1'b0, 13'h0, 13'h0100, 14'd4, 32'hDEADBEEF, 1'b1, a);
    for (int i = 0; i < 4; i++)
      push_wr(13'(13'h0100 + i), 32'hDEADBEEF, a + i);
    push_dn(2'd0, a + 4);
    wait_idle();
    chk("mem fill 0x103", 64'(mem[13'h0103]), 64'hDEADBEEF);

    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
    issue(1'b1, 13'h0, 13'h1000, 14'd3, 32'h0, 1'b1, a);
    push_wr(13'h1000, 32'h11, a + 1);
    push_wr(13'h1001, 32'h22, a + 3);
    push_wr(13'h1002, 32'h33, a + 5);
    push_dn(2'd0, a + 6);
    wait_idle();
    chk("mem copy 0x1002", 64'(mem[13'h1002]), 64'h33);

    issue(1'b0, 13'h0, 13'h1FFE, 14'd4, 32'hCAFEF00D, 1'b1, a);
    push_wr(13'h1FFE, 32'hCAFEF00D, a);
    push_wr(13'h1FFF, 32'hCAFEF00D, a + 1);
    push_wr(13'h0000, 32'hCAFEF00D, a + 2);
    push_wr(13'h0001, 32'hCAFEF00D, a + 3);
    push_dn(2'd0, a + 4);
    wait_idle();

    issue(1'b0, 13'h0, 13'h0040, 14'd0, 32'h1234, 1'b0, a);
    push_dn(2'd1, a);
    wait_idle();
    issue(1'b1, 13'h0, 13'h0040, 14'h2001, 32'h1234, 1'b0, a);
    push_dn(2'd1, a);
    wait_idle();

    for (int i = 0; i < 8; i++) mem[13'h0200 + i] = 32'hA0 + i;
    issue(1'b1, 13'h0200, 13'h0300, 14'd8, 32'h0, 1'b1, a);
    for (int i = 0; i < 3; i++)
      push_wr(13'(13'h0300 + i), 32'hA0 + i, a + 1 + 2 * i);
    push_dn(2'd2, a + 6);
    repeat (4) @(posedge clk);
    #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    wait_idle();
    chk("abort no 4th", 64'(mem[13'h0303]), 64'h0);

    abort = 1;
    repeat (3) @(negedge clk);
    abort = 0;
    issue(1'b0, 13'h0, 13'h0600, 14'd2, 32'h600D600D, 1'b1, a);
    push_wr(13'h0600, 32'h600D600D, a);
    push_wr(13'h0601, 32'h600D600D, a + 1);
    push_dn(2'd0, a + 2);
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    wait_idle();

    mem[13'h0700] = 32'h1; mem[13'h0701] = 32'h2;
    mem[13'h0702] = 32'h3;
    issue(1'b1, 13'h0700, 13'h0701, 14'd3, 32'h0, 1'b1, a);
    push_wr(13'h0701, 32'h1, a + 1);
    push_wr(13'h0702, 32'h1, a + 3);
    push_wr(13'h0703, 32'h1, a + 5);
    push_dn(2'd0, a + 6);
    wait_idle();

    issue(1'b0, 13'h0, 13'h0400, 14'd10, 32'h5A5A5A5A, 1'b1, a);
    push_wr(13'h0400, 32'h5A5A5A5A, a);
    @(posedge clk); #1 reset = 1;
    #1;
    chk("mid rst cs", 64'(mem_chipselect), 64'd0);
    chk("mid rst write", 64'(mem_write), 64'd0);
    chk("mid rst busy", 64'(busy), 64'd0);
    chk("mid rst done", 64'(done), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    chk("rst kept 0x400", 64'(mem[13'h0400]), 64'h5A5A5A5A);
    chk("rst no 0x401", 64'(mem[13'h0401]), 64'h0);
    chk("rst wq drained", 64'(wq.size()), 64'd0);
    issue(1'b0, 13'h0, 13'h0500, 14'd1, 32'h77, 1'b1, a);
    push_wr(13'h0500, 32'h77, a);
    push_dn(2'd0, a + 1);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
